// File: rtl/ntr_word_fetch_if.sv
// ntr_word_fetch_if: control, memory-read and serializer bus of ntr_word_fetch (NTR_FETCH_UNDERRUN_CNT_EN adds underrun_cnt)
interface ntr_word_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W = 10
);
  logic start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0] word_count;
  logic busy;
  logic done;
  logic mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_ack;
  logic [31:0] mem_data;
  logic resp_en;
  logic resp_request;
  logic [31:0] resp_data;
  logic underrun;
`ifdef NTR_FETCH_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
  modport slave(
    input start, start_addr, word_count, mem_ack, mem_data, resp_en, resp_request,
    output busy, done, mem_rd, mem_addr, resp_data, underrun, underrun_cnt
  );
  modport master(
    output start, start_addr, word_count, mem_ack, mem_data, resp_en, resp_request,
    input busy, done, mem_rd, mem_addr, resp_data, underrun, underrun_cnt
  );
`else
  modport slave(
    input start, start_addr, word_count, mem_ack, mem_data, resp_en, resp_request,
    output busy, done, mem_rd, mem_addr, resp_data, underrun
  );
  modport master(
    output start, start_addr, word_count, mem_ack, mem_data, resp_en, resp_request,
    input busy, done, mem_rd, mem_addr, resp_data, underrun
  );
`endif
endinterface

// File: rtl/ntr_word_fetch.sv
// ntr_word_fetch: sequential word prefetch into a FIFO for the NTR byte serializer (NTR_FETCH_UNDERRUN_CNT_EN adds saturating underrun_cnt)
module ntr_word_fetch #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W = 10
)(
  input logic clk,
  input logic rst_n,
  ntr_word_fetch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] fifo_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d, rem_n;
  logic rd_q, rd_d, done_q, done_d, unr_q, unr_d;
  logic accept, ack, pop_req, pop, empty_pop;
  always_comb begin
    accept = state_q == IDLE && bus.start;
    ack = rd_q && bus.mem_ack;
    pop_req = state_q != IDLE && bus.resp_en && bus.resp_request;
    pop = pop_req && cnt_q != '0;
    empty_pop = pop_req && cnt_q == '0;
    cnt_d = cnt_q + (PW+1)'(ack) - (PW+1)'(pop);
    wp_d = wp_q + PW'(ack);
    rp_d = rp_q + PW'(pop);
    rem_n = rem_q - CNT_W'(ack);
    addr_d = accept ? bus.start_addr : addr_q + ADDR_W'(ack);
    rem_d = accept ? bus.word_count : rem_n;
    rd_d = (state_q == FETCH && ((rd_q && !ack) || (rem_n != '0 && cnt_d != FULL))) || (accept && bus.word_count != '0);
    unr_d = !accept && (unr_q || empty_pop);
    done_d = (accept && bus.word_count == '0) || (state_q == DRAIN && pop && cnt_q == (PW+1)'(1));
    state_d = accept ? (bus.word_count == '0 ? IDLE : FETCH) :
              (state_q == FETCH && rem_n == '0) ? DRAIN :
              done_d ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      rd_q <= 1'b0;
      done_q <= 1'b0;
      unr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      rd_q <= rd_d;
      done_q <= done_d;
      unr_q <= unr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ack) fifo_q[wp_q] <= bus.mem_data;
  end
`ifdef NTR_FETCH_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;
  always_comb ucnt_d = accept ? '0 : ucnt_q + 8'(empty_pop && ucnt_q != 8'hFF);
  always_ff @(posedge clk) begin
    if (!rst_n) ucnt_q <= '0;
    else ucnt_q <= ucnt_d;
  end
  assign bus.underrun_cnt = ucnt_q;
`endif
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.mem_rd = rd_q;
  assign bus.mem_addr = addr_q;
  assign bus.resp_data = cnt_q == '0 ? '0 : fifo_q[rp_q];
  assign bus.underrun = unr_q;
endmodule

// File: tb/tb_ntr_word_fetch.sv
// tb_ntr_word_fetch: directed stimulus with expected-word scoreboard for ntr_word_fetch
module tb_ntr_word_fetch;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  ntr_word_fetch_if bus();
  ntr_word_fetch dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_vec = 0, n_err = 0, n_acks = 0, mem_delay = 1, w = 0, n0 = 0;
  logic mem_auto = 1, a_ack = 0, m_ack = 0;
  logic [31:0] a_data = 0, m_data = 0;
  logic [15:0] exp_addr = 0;
  logic [31:0] exp_q[$];
  assign bus.mem_ack = mem_auto ? a_ack : m_ack;
  assign bus.mem_data = mem_auto ? a_data : m_data;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start_xfer(input logic [15:0] a, input logic [9:0] c);
    bus.start_addr = a;
    bus.word_count = c;
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask
  task automatic pop_once();
    bus.resp_request = 1;
    tick();
    bus.resp_request = 0;
  endtask
  task automatic wait_done(input int lim);
    int k = 0;
    while (!bus.done && k < lim) begin
      tick();
      k++;
    end
    check("done_seen", {31'h0, bus.done}, 32'h1);
  endtask
  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({16'h0, base + 16'(i)});
  endtask
  always @(negedge clk) begin
    if (!mem_auto || !rst_n || !bus.mem_rd) begin
      a_ack = 0;
      w = 0;
    end else if (w >= mem_delay) begin
      a_ack = 1;
      a_data = {16'h0, bus.mem_addr};
      w = 0;
      n_acks++;
      check("mem_addr", {16'h0, bus.mem_addr}, {16'h0, exp_addr});
      exp_addr++;
    end else begin
      a_ack = 0;
      w++;
    end
  end
  always @(negedge clk) begin
    if (rst_n && bus.busy && bus.resp_en && bus.resp_request && bus.resp_data != 0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL resp_data: got %h expected no word", bus.resp_data);
      end else check("resp_data", bus.resp_data, exp_q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 0;
    bus.start_addr = 0;
    bus.word_count = 0;
    bus.resp_en = 0;
    bus.resp_request = 0;
    tick(2);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
    check("rst_underrun", {31'h0, bus.underrun}, 32'h0);
    check("rst_resp_data", bus.resp_data, 32'h0);
    check("rst_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
    rst_n = 1;
    bus.resp_en = 1;
    tick();
    exp_addr = 16'h0100;
    push_words(16'h0100, 3);
    start_xfer(16'h0100, 3);
    check("t2_busy", {31'h0, bus.busy}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick(3);
      if (i == 2) check("t2_done_early", {31'h0, bus.done}, 32'h0);
      pop_once();
    end
    check("t2_done", {31'h0, bus.done}, 32'h1);
    check("t2_busy_fall", {31'h0, bus.busy}, 32'h0);
    check("t2_underrun", {31'h0, bus.underrun}, 32'h0);
    tick();
    check("t2_done_pulse", {31'h0, bus.done}, 32'h0);
    exp_addr = 16'h0200;
    mem_delay = 0;
    push_words(16'h0200, 8);
    n0 = n_acks;
    start_xfer(16'h0200, 8);
    tick(20);
    check("t3_reads", n_acks - n0, 4);
    check("t3_rd_stall", {31'h0, bus.mem_rd}, 32'h0);
    pop_once();
    check("t3_rd_resume", {31'h0, bus.mem_rd}, 32'h1);
    check("t3_addr_resume", {16'h0, bus.mem_addr}, 32'h0204);
    for (int i = 0; i < 7; i++) begin
      tick();
      pop_once();
    end
    wait_done(5);
    check("t3_underrun", {31'h0, bus.underrun}, 32'h0);
    tick();
    exp_addr = 16'h0300;
    mem_delay = 10;
    push_words(16'h0300, 2);
    bus.resp_request = 1;
    start_xfer(16'h0300, 2);
    tick(3);
    check("t4_busy", {31'h0, bus.busy}, 32'h1);
    check("t4_empty_data", bus.resp_data, 32'h0);
    check("t4_underrun_set", {31'h0, bus.underrun}, 32'h1);
    wait_done(60);
    bus.resp_request = 0;
    check("t4_underrun_sticky", {31'h0, bus.underrun}, 32'h1);
`ifdef NTR_FETCH_UNDERRUN_CNT_EN
    check("t4_underrun_cnt_nz", {31'h0, bus.underrun_cnt != 8'h0}, 32'h1);
`endif
    tick();
    start_xfer(16'h0777, 0);
    check("t5_zero_done", {31'h0, bus.done}, 32'h1);
    check("t5_zero_busy", {31'h0, bus.busy}, 32'h0);
    check("t5_zero_rd", {31'h0, bus.mem_rd}, 32'h0);
    check("t5_underrun_clr", {31'h0, bus.underrun}, 32'h0);
`ifdef NTR_FETCH_UNDERRUN_CNT_EN
    check("t5_underrun_cnt_clr", {24'h0, bus.underrun_cnt}, 32'h0);
`endif
    tick();
    check("t5_done_pulse", {31'h0, bus.done}, 32'h0);
    check("t5_no_rd", {31'h0, bus.mem_rd}, 32'h0);
    exp_addr = 16'h0400;
    mem_delay = 1;
    push_words(16'h0400, 2);
    n0 = n_acks;
    start_xfer(16'h0400, 2);
    tick();
    start_xfer(16'h0900, 5);
    tick(4);
    pop_once();
    tick(2);
    pop_once();
    wait_done(3);
    check("t5_reads", n_acks - n0, 2);
    check("t5_busy", {31'h0, bus.busy}, 32'h0);
    tick();
    mem_auto = 0;
    start_xfer(16'h0500, 4);
    check("t6_rd", {31'h0, bus.mem_rd}, 32'h1);
    rst_n = 0;
    tick();
    check("t6_rd_abort", {31'h0, bus.mem_rd}, 32'h0);
    check("t6_busy_abort", {31'h0, bus.busy}, 32'h0);
    rst_n = 1;
    m_ack = 1;
    m_data = 32'hDEAD_BEEF;
    tick();
    m_ack = 0;
    tick();
    check("t6_late_ack", bus.resp_data, 32'h0);
    check("t6_busy", {31'h0, bus.busy}, 32'h0);
    check("t6_rd", {31'h0, bus.mem_rd}, 32'h0);
    check("words_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
